// File: rtl/alu_bist.sv
// Built-in self-test initiator for the 32-bit ALU: drives LFSR vectors, checks results against a golden model.
// Optional ALU_BIST_CORNER_EN prepends 8 fixed corner vectors ahead of the random ones.
module alu_bist #(
  parameter int          NUM_VECTORS   = 64,
  parameter logic [31:0] SEED          = 32'hACE1_2345,
  parameter int          SETTLE_CYCLES = 1,
  parameter int          CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_f,
  input  logic [31:0]      alu_y,
  input  logic             alu_zero,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] fail_count,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [31:0]      first_fail_a,
  output logic [31:0]      first_fail_b,
  output logic [2:0]       first_fail_f
);

`ifdef ALU_BIST_CORNER_EN
  localparam int NCORNER = 8;
`else
  localparam int NCORNER = 0;
`endif
  localparam int          TOTAL       = NUM_VECTORS + NCORNER;
  localparam logic [31:0] LAST_IDX    = 32'(TOTAL - 1);
  localparam logic [31:0] SEED_EFF    = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] LFSR_MASK   = 32'h8020_0003;
  localparam logic [31:0] SETTLE_INIT = 32'(SETTLE_CYCLES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_MASK : 32'h0);
  endfunction

  function automatic logic [2:0] op_code(input logic [2:0] k);
    case (k)
      3'd0:    return 3'b000;
      3'd1:    return 3'b001;
      3'd2:    return 3'b010;
      3'd3:    return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (f)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return (sa < sb) ? 32'h1 : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

`ifdef ALU_BIST_CORNER_EN
  function automatic logic [66:0] corner_vec(input logic [2:0] i);
    case (i)
      3'd0:    return {32'h0000_0000, 32'h0000_0000, 3'b010};
      3'd1:    return {32'h0000_0000, 32'hFFFF_FFFF, 3'b010};
      3'd2:    return {32'h0000_0001, 32'hFFFF_FFFF, 3'b010};
      3'd3:    return {32'h0000_00FF, 32'h0000_0001, 3'b010};
      3'd4:    return {32'h0000_0100, 32'h0000_0001, 3'b110};
      3'd5:    return {32'hFFFF_FFFF, 32'h0000_0000, 3'b111};
      3'd6:    return {32'h0000_0000, 32'hFFFF_FFFF, 3'b111};
      default: return {32'hFFFF_FFFF, 32'h1234_5678, 3'b000};
    endcase
  endfunction
`endif

  logic [2:0]       state_q, state_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [31:0]      idx_q, idx_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      wait_q, wait_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [2:0]       f_q, f_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             ffv_q, ffv_d;
  logic [CNT_W-1:0] ffidx_q, ffidx_d;
  logic [31:0]      ffa_q, ffa_d, ffb_q, ffb_d;
  logic [2:0]       fff_q, fff_d;

  logic [31:0]      gold_y;
  logic             mism;
  logic [CNT_W-1:0] fail_next;

  assign gold_y    = golden(a_q, b_q, f_q);
  assign mism      = (alu_y != gold_y) || (alu_zero != (gold_y == 32'h0));
  assign fail_next = mism ? sat_inc(fail_q) : fail_q;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    op_d    = op_q;
    wait_d  = wait_q;
    a_d     = a_q;
    b_d     = b_q;
    f_d     = f_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    ffv_d   = ffv_q;
    ffidx_d = ffidx_q;
    ffa_d   = ffa_q;
    ffb_d   = ffb_q;
    fff_d   = fff_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          lfsr_d  = SEED_EFF;
          idx_d   = 32'h0;
          op_d    = 3'd0;
          fail_d  = '0;
          ffv_d   = 1'b0;
          ffidx_d = '0;
          ffa_d   = 32'h0;
          ffb_d   = 32'h0;
          fff_d   = 3'b000;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
`ifdef ALU_BIST_CORNER_EN
        if (idx_q < 32'd8) begin
          {a_d, b_d, f_d} = corner_vec(idx_q[2:0]);
        end else begin
`endif
          // Random vectors consume two LFSR steps: one for each operand.
          a_d    = lfsr_q;
          b_d    = lfsr_step(lfsr_q);
          lfsr_d = lfsr_step(lfsr_step(lfsr_q));
          f_d    = op_code(op_q);
          op_d   = (op_q == 3'd4) ? 3'd0 : op_q + 3'd1;
`ifdef ALU_BIST_CORNER_EN
        end
`endif
        wait_d  = SETTLE_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wait_d = wait_q - 32'd1;
        if (wait_q == 32'd1) state_d = S_CHECK;
      end
      S_CHECK: begin
        fail_d = fail_next;
        if (mism && !ffv_q) begin
          ffv_d   = 1'b1;
          ffidx_d = idx_q[CNT_W-1:0];
          ffa_d   = a_q;
          ffb_d   = b_q;
          fff_d   = f_q;
        end
        if (idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_next == '0);
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 32'd1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      idx_q   <= 32'h0;
      op_q    <= 3'd0;
      wait_q  <= 32'h0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      f_q     <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
      ffv_q   <= 1'b0;
      ffidx_q <= '0;
      ffa_q   <= 32'h0;
      ffb_q   <= 32'h0;
      fff_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      ffv_q   <= ffv_d;
      ffidx_q <= ffidx_d;
      ffa_q   <= ffa_d;
      ffb_q   <= ffb_d;
      fff_q   <= fff_d;
    end
  end

  assign alu_a            = a_q;
  assign alu_b            = b_q;
  assign alu_f            = f_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail_count       = fail_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffidx_q;
  assign first_fail_a     = ffa_q;
  assign first_fail_b     = ffb_q;
  assign first_fail_f     = fff_q;

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: table of ALU fault modes plus reset-abort, held-start and saturation sequences.
module tb_alu_bist;
  localparam int NV = 10;
`ifdef ALU_BIST_CORNER_EN
  localparam int NC = 8;
`else
  localparam int NC = 0;
`endif
  localparam int          TOT  = NV + NC;
  localparam logic [31:0] SEED = 32'hACE1_2345;
  localparam int          P0   = 3;
  localparam int          P1   = 4;

  logic clk = 1'b0;
  logic reset, start0, start1;
  always #5 clk = ~clk;

  logic [31:0] a0, b0, y0, ffa0, ffb0;
  logic [2:0]  f0, fff0;
  logic        z0, busy0, done0, pass0, ffv0;
  logic [15:0] fc0, ffi0;
  logic [31:0] a1, b1, y1, ffa1, ffb1;
  logic [2:0]  f1, fff1;
  logic        z1, busy1, done1, pass1, ffv1;
  logic [1:0]  fc1, ffi1;

  int fault;
  int nvec = 0;
  int nbad = 0;
  logic [31:0] ea [TOT];
  logic [31:0] eb [TOT];
  logic [2:0]  ef [TOT];

  alu_bist #(.NUM_VECTORS(NV), .SEED(SEED), .SETTLE_CYCLES(1), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .start(start0), .alu_a(a0), .alu_b(b0), .alu_f(f0),
    .alu_y(y0), .alu_zero(z0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_count(fc0), .first_fail_valid(ffv0), .first_fail_idx(ffi0),
    .first_fail_a(ffa0), .first_fail_b(ffb0), .first_fail_f(fff0));

  alu_bist #(.NUM_VECTORS(NV), .SEED(SEED), .SETTLE_CYCLES(2), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .start(start1), .alu_a(a1), .alu_b(b1), .alu_f(f1),
    .alu_y(y1), .alu_zero(z1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_count(fc1), .first_fail_valid(ffv1), .first_fail_idx(ffi1),
    .first_fail_a(ffa1), .first_fail_b(ffb1), .first_fail_f(fff1));

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f);
    case (f)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a + ~b + 32'h1;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  // Fault modes: 0 good ALU, 1 SUB computed as ADD, 2 zero flag stuck low, 3 constant 0xDEADBEEF.
  always_comb begin
    y0 = ref_alu(a0, b0, (fault == 1 && f0 == 3'b110) ? 3'b010 : f0);
    z0 = (y0 == 32'h0);
    if (fault == 2) z0 = 1'b0;
    if (fault == 3) begin
      y0 = 32'hDEAD_BEEF;
      z0 = 1'b0;
    end
  end
  assign y1 = 32'hDEAD_BEEF;
  assign z1 = 1'b0;

  function automatic logic [31:0] step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  task automatic build_vectors();
    logic [31:0] s;
    logic [31:0] ca [8] = '{32'h0, 32'h0, 32'h1, 32'hFF, 32'h100, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF};
    logic [31:0] cb [8] = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678};
    logic [2:0]  cf [8] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b110, 3'b111, 3'b111, 3'b000};
    logic [2:0]  ops [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    s = SEED;
    for (int k = 0; k < TOT; k++) begin
      if (k < NC) begin
        ea[k] = ca[k]; eb[k] = cb[k]; ef[k] = cf[k];
      end else begin
        ea[k] = s;
        eb[k] = step(s);
        s     = step(eb[k]);
        ef[k] = ops[(k - NC) % 5];
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset0();
    chk("rst_a", a0, 0);      chk("rst_b", b0, 0);     chk("rst_f", f0, 0);
    chk("rst_busy", busy0, 0); chk("rst_done", done0, 0); chk("rst_pass", pass0, 0);
    chk("rst_fc", fc0, 0);    chk("rst_ffv", ffv0, 0); chk("rst_ffi", ffi0, 0);
    chk("rst_ffa", ffa0, 0);  chk("rst_ffb", ffb0, 0); chk("rst_fff", fff0, 0);
  endtask

  typedef struct {
    int         fault;
    int         exp_fail;   // -1: not checked
    bit         exp_ffv;
    int         exp_idx;
    logic [2:0] exp_f;
    bit         exp_pass;
  } rec_t;
  rec_t tbl [5];
  int   ntbl;

  // Pulse start (or hold it when keep=1) and follow u0 through a run, checking each driven vector.
  task automatic follow_u0(input int flt, input bit keep, output int c);
    bit seen;
    @(negedge clk);
    fault  = flt;
    start0 = 1'b1;
    @(negedge clk);
    if (!keep) start0 = 1'b0;
    chk("busy_rise", busy0, 1);
    chk("done_clear", done0, 0);
    c = 0;
    seen = 1'b0;
    while (!seen && c <= TOT * P0 + 5) begin
      if (c % P0 == 1 && c / P0 < TOT) begin
        chk($sformatf("vec%0d_a", c / P0), a0, ea[c / P0]);
        chk($sformatf("vec%0d_b", c / P0), b0, eb[c / P0]);
        chk($sformatf("vec%0d_f", c / P0), f0, ef[c / P0]);
      end
      if (done0) seen = 1'b1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    chk("done_latency", c, TOT * P0);
  endtask

  task automatic run_rec(input rec_t r);
    int c;
    follow_u0(r.fault, 1'b0, c);
    chk("busy_end", busy0, 0);
    chk("pass", pass0, r.exp_pass);
    if (r.exp_fail >= 0) chk("fail_count", fc0, r.exp_fail);
    chk("ff_valid", ffv0, r.exp_ffv);
    chk("ff_idx", ffi0, r.exp_idx);
    chk("ff_f", fff0, r.exp_f);
    chk("ff_a", ffa0, r.exp_ffv ? ea[r.exp_idx] : 32'h0);
    chk("ff_b", ffb0, r.exp_ffv ? eb[r.exp_idx] : 32'h0);
    chk("hold_a", a0, ea[TOT - 1]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    bit seen;
    build_vectors();
`ifdef ALU_BIST_CORNER_EN
    tbl[0] = '{0, 0,   1'b0, 0, 3'b000, 1'b1};
    tbl[1] = '{1, 3,   1'b1, 4, 3'b110, 1'b0};
    tbl[2] = '{2, -1,  1'b1, 0, 3'b010, 1'b0};
    tbl[3] = '{3, TOT, 1'b1, 0, 3'b010, 1'b0};
    tbl[4] = '{0, 0,   1'b0, 0, 3'b000, 1'b1};
    ntbl = 5;
`else
    tbl[0] = '{0, 0,   1'b0, 0, 3'b000, 1'b1};
    tbl[1] = '{1, 2,   1'b1, 3, 3'b110, 1'b0};
    tbl[2] = '{3, TOT, 1'b1, 0, 3'b000, 1'b0};
    tbl[3] = '{0, 0,   1'b0, 0, 3'b000, 1'b1};
    ntbl = 4;
`endif
    fault = 0; reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_reset0();
    chk("rst_u1_fc", fc1, 0);
    repeat (2) @(negedge clk);
    chk("idle_no_start", busy0, 0);

    for (int i = 0; i < ntbl; i++) run_rec(tbl[i]);

    // Abort during WAIT of vector 4, then rerun from scratch.
    @(negedge clk);
    fault = 0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (4 * P0 + 1) @(negedge clk);
    chk("mid_busy", busy0, 1);
    chk("mid_a", a0, ea[4]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset0();
    repeat (2) @(negedge clk);
    chk("post_rst_idle", busy0, 0);
    run_rec(tbl[0]);

    // start held high: no restart while busy, restart straight out of DONE.
    follow_u0(1, 1'b1, c);
    chk("held_fc_done", fc0, tbl[1].exp_fail);
    @(negedge clk);
    chk("held_restart_done", done0, 0);
    chk("held_restart_busy", busy0, 1);
    chk("held_restart_fc", fc0, 0);
    start0 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Narrow counters on u1 with an always-wrong ALU.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("u1_busy_rise", busy1, 1);
    c = 0;
    seen = 1'b0;
    while (!seen && c <= TOT * P1 + 5) begin
      if (c % P1 == 1 && c / P1 < TOT) chk($sformatf("u1_vec%0d_a", c / P1), a1, ea[c / P1]);
      if (done1) seen = 1'b1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    chk("u1_done_latency", c, TOT * P1);
    chk("u1_fc_sat", fc1, 3);
    chk("u1_ff_valid", ffv1, 1);
    chk("u1_ff_idx", ffi1, 0);
    chk("u1_ff_a", ffa1, ea[0]);
    chk("u1_ff_b", ffb1, eb[0]);
    chk("u1_ff_f", fff1, ef[0]);
    chk("u1_pass", pass1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
